// File: rtl/add_two_streams_pkg.sv
// add_two_streams_pkg: shared width, queue depth and FSM state type for the stream adder
package add_two_streams_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 256;
  typedef enum logic {S_READ, S_WRITE} state_t;
endpackage

// File: rtl/add_two_streams_fifo.sv
// add_two_streams_fifo: first-word-fall-through FIFO used for the A, B and sum queues
module add_two_streams_fifo
  import add_two_streams_pkg::*;
#(
  parameter int FIFO_BUFFER_SIZE = FIFO_DEPTH,
  parameter int FIFO_DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       rd_clk,
  input  logic                       wr_clk,
  input  logic                       reset,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] din,
  output logic [FIFO_DATA_WIDTH-1:0] dout,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(FIFO_BUFFER_SIZE);
  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
  logic [AW:0] wr_ptr, rd_ptr, count;
  // Pointers carry one wrap bit so the difference distinguishes full from empty.
  always_comb begin
    count = wr_ptr - rd_ptr;
    full = count == (AW+1)'(FIFO_BUFFER_SIZE);
    empty = count == '0;
    dout = mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge wr_clk)
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge wr_clk)
    if (reset) wr_ptr <= '0;
    else if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
  always_ff @(posedge rd_clk)
    if (reset) rd_ptr <= '0;
    else if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
endmodule

// File: rtl/add_two_streams.sv
// add_two_streams: pops one word from each of FIFOs A and B and pushes their wrapped sum
module add_two_streams
  import add_two_streams_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  inA_rd_en,
  input  logic                  inA_empty,
  input  logic [DATA_WIDTH-1:0] inA_dout,
  output logic                  inB_rd_en,
  input  logic                  inB_empty,
  input  logic [DATA_WIDTH-1:0] inB_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din
);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] sum;
  logic can_read;
  // Strobes are gated by reset so nothing moves while reset is held.
  always_comb begin
    can_read = !reset && state == S_READ && !inA_empty && !inB_empty;
    inA_rd_en = can_read;
    inB_rd_en = can_read;
    out_wr_en = !reset && state == S_WRITE && !out_full;
    out_din = reset ? '0 : sum;
    state_n = can_read ? S_WRITE : out_wr_en ? S_READ : state;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_READ;
      sum <= '0;
    end else begin
      state <= state_n;
      if (can_read) sum <= inA_dout + inB_dout;
    end
endmodule

// File: tb/tb_add_two_streams.sv
// tb_add_two_streams: FIFO-wrapped adder checked against a queue-based pairwise-sum model
module tb_add_two_streams;
  logic clk = 1'b0;
  logic rst, dut_rst;
  logic a_wr, b_wr, s_rd;
  logic [31:0] a_din, b_din, a_dout, b_dout, s_din, s_dout;
  logic a_full, a_empty, b_full, b_empty, s_full, s_empty;
  logic inA_rd_en, inB_rd_en, out_wr_en;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] qa[$], qb[$], qexp[$];

  always #5 clk = ~clk;

  add_two_streams_fifo #(.FIFO_BUFFER_SIZE(256), .FIFO_DATA_WIDTH(32)) fifo_a (
    .rd_clk(clk), .wr_clk(clk), .reset(rst), .rd_en(inA_rd_en), .wr_en(a_wr),
    .din(a_din), .dout(a_dout), .full(a_full), .empty(a_empty));
  add_two_streams_fifo #(.FIFO_BUFFER_SIZE(256), .FIFO_DATA_WIDTH(32)) fifo_b (
    .rd_clk(clk), .wr_clk(clk), .reset(rst), .rd_en(inB_rd_en), .wr_en(b_wr),
    .din(b_din), .dout(b_dout), .full(b_full), .empty(b_empty));
  add_two_streams_fifo #(.FIFO_BUFFER_SIZE(256), .FIFO_DATA_WIDTH(32)) fifo_s (
    .rd_clk(clk), .wr_clk(clk), .reset(rst), .rd_en(s_rd), .wr_en(out_wr_en),
    .din(s_din), .dout(s_dout), .full(s_full), .empty(s_empty));

  add_two_streams #(.DATA_WIDTH(32)) dut (
    .clock(clk), .reset(dut_rst),
    .inA_rd_en(inA_rd_en), .inA_empty(a_empty), .inA_dout(a_dout),
    .inB_rd_en(inB_rd_en), .inB_empty(b_empty), .inB_dout(b_dout),
    .out_wr_en(out_wr_en), .out_full(s_full), .out_din(s_din));

  // Handshake rules hold on every cycle: paired pops, never pop empty, never push full.
  always @(negedge clk) begin
    vectors++;
    assert (inA_rd_en === inB_rd_en && !(inA_rd_en && a_empty) && !(inB_rd_en && b_empty)
            && !(out_wr_en && s_full))
    else begin
      miscompares++;
      $error("FAIL strobe_rules observed rdA=%b rdB=%b wr=%b eA=%b eB=%b full=%b",
             inA_rd_en, inB_rd_en, out_wr_en, a_empty, b_empty, s_full);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic do_a, input logic do_b, input logic [31:0] va,
                      input logic [31:0] vb, input bit track);
    a_wr = do_a; a_din = va; b_wr = do_b; b_din = vb;
    tick();
    a_wr = 1'b0; b_wr = 1'b0;
    if (track) begin
      if (do_a) qa.push_back(va);
      if (do_b) qb.push_back(vb);
      while (qa.size() > 0 && qb.size() > 0) qexp.push_back(qa.pop_front() + qb.pop_front());
    end
  endtask

  task automatic drain(input string tag);
    logic [31:0] exp;
    while (qexp.size() > 0) begin
      exp = qexp.pop_front();
      for (int i = 0; i < 40 && s_empty; i++) tick();
      check({tag, "_avail"}, {31'd0, s_empty}, 32'd0);
      if (!s_empty) begin
        check(tag, s_dout, exp);
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; dut_rst = 1'b1;
    a_wr = 1'b0; b_wr = 1'b0; s_rd = 1'b0; a_din = '0; b_din = '0;
    repeat (3) tick();
    check("rst_rdA", {31'd0, inA_rd_en}, 32'd0);
    check("rst_wr", {31'd0, out_wr_en}, 32'd0);
    rst = 1'b0; dut_rst = 1'b0;
    tick();
    check("post_rst_rdB", {31'd0, inB_rd_en}, 32'd0);
    check("post_rst_wr", {31'd0, out_wr_en}, 32'd0);
    check("post_rst_din", s_din, 32'd0);

    push(1, 1, 32'd1, 32'd10, 1);
    push(1, 1, 32'd2, 32'd20, 1);
    push(1, 1, 32'd3, 32'd30, 1);
    drain("basic");

    push(1, 1, -32'sd5, 32'd3, 1);
    push(1, 1, 32'h7FFF_FFFF, 32'd1, 1);
    push(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    push(1, 1, 32'hFFFF_FFFF, 32'd1, 1);
    drain("wrap");

    for (int i = 0; i < 4; i++) push(1, 0, $urandom, 32'd0, 1);
    for (int i = 0; i < 10; i++) begin
      check("starve_rdA", {31'd0, inA_rd_en}, 32'd0);
      check("starve_wr", {31'd0, out_wr_en}, 32'd0);
      tick();
    end
    check("starve_a_kept", {31'd0, a_empty}, 32'd0);
    for (int i = 0; i < 4; i++) push(0, 1, 32'd0, $urandom, 1);
    drain("starve");

    for (int i = 0; i < 40; i++) push(1, 1, $urandom, $urandom, 1);
    drain("random");

    for (int i = 0; i < 260; i++) push(1, 1, $urandom, $urandom, 1);
    repeat (600) tick();
    check("bp_full", {31'd0, s_full}, 32'd1);
    check("bp_no_wr", {31'd0, out_wr_en}, 32'd0);
    check("bp_no_rd", {31'd0, inA_rd_en}, 32'd0);
    check("bp_a_left", {31'd0, a_empty}, 32'd0);
    drain("backpressure");

    push(1, 1, 32'd100, 32'd200, 0);
    for (int i = 0; i < 20 && !inA_rd_en; i++) tick();
    check("mid_pop", {31'd0, inA_rd_en}, 32'd1);
    tick();
    check("mid_latency_wr", {31'd0, out_wr_en}, 32'd1);
    check("mid_latency_din", s_din, 32'd300);
    dut_rst = 1'b1;
    #1;
    check("mid_rst_wr", {31'd0, out_wr_en}, 32'd0);
    tick();
    dut_rst = 1'b0;
    #1;
    check("mid_after_wr", {31'd0, out_wr_en}, 32'd0);
    check("mid_after_din", s_din, 32'd0);
    check("mid_discard", {31'd0, s_empty}, 32'd1);
    for (int i = 0; i < 6; i++) push(1, 1, $urandom, $urandom, 1);
    drain("mid_resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
